// File: rtl/mlu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, read selects and FSM states.
package mlu_pkg;

    localparam int MLU_OP_W  = 5;
    localparam int MLU_SEL_W = 3;

    localparam logic [MLU_OP_W-1:0] MLU_NONE  = 5'd0;
    localparam logic [MLU_OP_W-1:0] MLU_MULT  = 5'd1;
    localparam logic [MLU_OP_W-1:0] MLU_MULTU = 5'd2;
    localparam logic [MLU_OP_W-1:0] MLU_DIV   = 5'd3;
    localparam logic [MLU_OP_W-1:0] MLU_DIVU  = 5'd4;
    localparam logic [MLU_OP_W-1:0] MLU_MTHI  = 5'd5;
    localparam logic [MLU_OP_W-1:0] MLU_MTLO  = 5'd6;
    localparam logic [MLU_OP_W-1:0] MLU_FDIV  = 5'd7;

    localparam logic [MLU_SEL_W-1:0] MLU_OUT_NONE = 3'd0;
    localparam logic [MLU_SEL_W-1:0] MLU_OUT_HI   = 3'd1;
    localparam logic [MLU_SEL_W-1:0] MLU_OUT_LO   = 3'd2;

    typedef enum logic {
        MLU_IDLE = 1'b0,
        MLU_RUN  = 1'b1
    } mlu_state_t;

    function automatic logic is_mult_op(input logic [MLU_OP_W-1:0] op);
        return (op == MLU_MULT) || (op == MLU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [MLU_OP_W-1:0] op);
        return (op == MLU_DIV) || (op == MLU_DIVU) || (op == MLU_FDIV);
    endfunction

endpackage

// File: rtl/mlu_div_core.sv
// Combinational 32-bit divider: truncating signed, unsigned and floor-signed modes.
module mlu_div_core
    import mlu_pkg::*;
(
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    input  logic [MLU_OP_W-1:0] op,
    output logic [31:0]         quotient,
    output logic [31:0]         remainder,
    output logic                div_by_zero
);

    logic        signed_mode;
    logic        floor_mode;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] tq;
    logic [31:0] tr;

    always_comb begin
        signed_mode = (op == MLU_DIV) || (op == MLU_FDIV);
        floor_mode  = (op == MLU_FDIV);
        div_by_zero = (b == 32'd0);

        a_neg = signed_mode & a[31];
        b_neg = signed_mode & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
        // Keep the divider defined on b == 0; the result is discarded at commit.
        if (div_by_zero) begin
            b_mag = 32'd1;
        end

        // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 wraps back.
        uq = a_mag / b_mag;
        ur = a_mag % b_mag;
        tq = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        tr = a_neg ? (32'd0 - ur) : ur;

        quotient  = tq;
        remainder = tr;
        if (floor_mode && (tr != 32'd0) && (tr[31] != b[31])) begin
            quotient  = tq - 32'd1;
            remainder = tr + b;
        end
    end

endmodule

// File: rtl/mlu.sv
// E-stage multiply/divide unit: HI/LO registers, multi-cycle mult/div FSM and mfhi/mflo read port.
module mlu
    import mlu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [MLU_OP_W-1:0]  mlu_op,
    input  logic [31:0]          src_a,
    input  logic [31:0]          src_b,
    input  logic [MLU_SEL_W-1:0] mlu_out,
    output logic                 busy,
    output logic [31:0]          result,
    output logic [31:0]          hi_q,
    output logic [31:0]          lo_q
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mlu_state_t          state_reg, state_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [MLU_OP_W-1:0] op_reg, op_next;
    logic [31:0]         a_reg, a_next;
    logic [31:0]         b_reg, b_next;
    logic [31:0]         hi_reg, hi_next;
    logic [31:0]         lo_reg, lo_next;

    logic [63:0]         prod_s;
    logic [63:0]         prod_u;
    logic [31:0]         div_q;
    logic [31:0]         div_r;
    logic                div_by_zero;

    mlu_div_core u_div_core (
        .a           (a_reg),
        .b           (b_reg),
        .op          (op_reg),
        .quotient    (div_q),
        .remainder   (div_r),
        .div_by_zero (div_by_zero)
    );

    // Operands are sign/zero extended to 64 bits so the low 64 bits are the exact product.
    assign prod_s = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});
    assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= MLU_IDLE;
            count_reg <= '0;
            op_reg    <= MLU_NONE;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        unique case (state_reg)
            MLU_IDLE: begin
                if (start) begin
                    if (is_mult_op(mlu_op) || is_div_op(mlu_op)) begin
                        op_next    = mlu_op;
                        a_next     = src_a;
                        b_next     = src_b;
                        count_next = is_mult_op(mlu_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_next = MLU_RUN;
                    end else if (mlu_op == MLU_MTHI) begin
                        hi_next = src_a;
                    end else if (mlu_op == MLU_MTLO) begin
                        lo_next = src_a;
                    end
                end
            end
            MLU_RUN: begin
                // A start arriving here is ignored; the hazard unit prevents it.
                count_next = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    state_next = MLU_IDLE;
                    if (op_reg == MLU_MULT) begin
                        {hi_next, lo_next} = prod_s;
                    end else if (op_reg == MLU_MULTU) begin
                        {hi_next, lo_next} = prod_u;
                    end else if (is_div_op(op_reg) && !div_by_zero) begin
                        hi_next = div_r;
                        lo_next = div_q;
                    end
                end
            end
            default: begin
                state_next = MLU_IDLE;
            end
        endcase
    end

    assign busy = (state_reg == MLU_RUN);
    assign hi_q = hi_reg;
    assign lo_q = lo_reg;

    always_comb begin
        result = 32'd0;
        if (mlu_out == MLU_OUT_HI) begin
            result = hi_reg;
        end else if (mlu_out == MLU_OUT_LO) begin
            result = lo_reg;
        end
    end

endmodule
